// File: rtl/range_xfer_fifo_pkg.sv
// rtl/range_xfer_fifo_pkg.sv - range_xfer_pkg: geometry helpers and mode constants for range_xfer_fifo
package range_xfer_pkg;

   localparam int MODE_STRAIGHT = 0;
   localparam int MODE_CROSS    = 1;

   function automatic int range_w(input int hi, input int lo);
      return hi - lo + 1;
   endfunction

   function automatic int count_w(input int depth);
      return $clog2(depth + 1);
   endfunction

   function automatic int ptr_w(input int depth);
      return (depth > 1) ? $clog2(depth) : 1;
   endfunction

endpackage

// File: rtl/range_xfer_fifo_if.sv
// rtl/range_xfer_fifo_if.sv - producer/consumer bus of range_xfer_fifo; RANGE_XFER_FIFO_PARITY_EN adds parity signals
interface range_xfer_fifo_if #(
   parameter int HI    = 2,
   parameter int LO    = -2,
   parameter int DEPTH = 4
) ();

   logic                                        in_valid;
   logic                                        in_ready;
   logic [HI:LO]                                i0;
   logic [LO:HI]                                i1;
   logic                                        out_valid;
   logic                                        out_ready;
   logic [HI:LO]                                o0;
   logic [LO:HI]                                o1;
   logic [range_xfer_pkg::count_w(DEPTH)-1:0]   count;
`ifdef RANGE_XFER_FIFO_PARITY_EN
   logic                                        i_par;
   logic                                        o_par;
   logic                                        par_err;

   modport slave (
      input  in_valid, i0, i1, out_ready, i_par,
      output in_ready, out_valid, o0, o1, count, o_par, par_err
   );
   modport master (
      output in_valid, i0, i1, out_ready, i_par,
      input  in_ready, out_valid, o0, o1, count, o_par, par_err
   );
`else
   modport slave (
      input  in_valid, i0, i1, out_ready,
      output in_ready, out_valid, o0, o1, count
   );
   modport master (
      output in_valid, i0, i1, out_ready,
      input  in_ready, out_valid, o0, o1, count
   );
`endif

endinterface

// File: rtl/range_xfer_fifo_mem.sv
// rtl/range_xfer_fifo_mem.sv - range_xfer_mem: DEPTH x DW register array, one write port, one async read port
module range_xfer_mem #(
   parameter int DEPTH = 4,
   parameter int DW    = 10,
   parameter int AW    = 2
) (
   input  logic          clk,
   input  logic          we,
   input  logic [AW-1:0] waddr,
   input  logic [DW-1:0] wdata,
   input  logic [AW-1:0] raddr,
   output logic [DW-1:0] rdata
);

   logic [DW-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/range_xfer_fifo.sv
// rtl/range_xfer_fifo.sv - range_xfer_fifo: DEPTH-entry valid/ready FIFO for a [HI:LO]/[LO:HI] bus pair
// Optional macro RANGE_XFER_FIFO_PARITY_EN adds o_par, i_par and sticky par_err.
module range_xfer_fifo import range_xfer_pkg::*; #(
   parameter int HI    = 2,
   parameter int LO    = -2,
   parameter int DEPTH = 4,
   parameter int MODE  = MODE_STRAIGHT
) (
   input  logic               clk,
   input  logic               rst,
   range_xfer_fifo_if.slave   bus
);

   localparam int W  = range_w(HI, LO);
   localparam int CW = count_w(DEPTH);
   localparam int PW = ptr_w(DEPTH);

   typedef logic [PW-1:0] ptr_t;
   typedef struct packed {
      logic [HI:LO] d0;
      logic [LO:HI] d1;
   } entry_t;

   ptr_t          wr_ptr, rd_ptr, rd_ptr_nx;
   logic [CW-1:0] cnt, cnt_nx;
   logic          out_valid_q;
   logic [HI:LO]  o0_q, m0;
   logic [LO:HI]  o1_q, m1;
   logic          push, pop;
   entry_t        wr_entry, rd_entry, head_entry;
   logic [2*W-1:0] rd_data;

   function automatic ptr_t ptr_inc(input ptr_t p);
      return (p == ptr_t'(DEPTH - 1)) ? '0 : p + ptr_t'(1);
   endfunction

   assign bus.in_ready  = (cnt != CW'(DEPTH));
   assign push          = bus.in_valid & bus.in_ready;
   assign pop           = out_valid_q & bus.out_ready;
   assign wr_entry.d0   = bus.i0;
   assign wr_entry.d1   = bus.i1;
   assign rd_ptr_nx     = pop ? ptr_inc(rd_ptr) : rd_ptr;

   always_comb begin
      cnt_nx = cnt;
      case ({push, pop})
         2'b10:   cnt_nx = cnt + CW'(1);
         2'b01:   cnt_nx = cnt - CW'(1);
         default: cnt_nx = cnt;
      endcase
   end

   range_xfer_mem #(
      .DEPTH (DEPTH),
      .DW    (2 * W),
      .AW    (PW)
   ) u_mem (
      .clk   (clk),
      .we    (push & ~rst),
      .waddr (wr_ptr),
      .wdata (wr_entry),
      .raddr (rd_ptr_nx),
      .rdata (rd_data)
   );

   assign rd_entry = entry_t'(rd_data);

   // The next head is the word being written when the FIFO would otherwise run dry.
   assign head_entry = (push && (wr_ptr == rd_ptr_nx)) ? wr_entry : rd_entry;

   // Index-for-index mapping: bit k of the source lands on bit k of the destination.
   if (MODE == MODE_CROSS) begin : g_cross
      for (genvar j = 0; j < W; j++) begin : g_bit
         localparam int K = LO + j;
         assign m0[K] = head_entry.d1[K];
         assign m1[K] = head_entry.d0[K];
      end
   end else begin : g_straight
      assign m0 = head_entry.d0;
      assign m1 = head_entry.d1;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr      <= '0;
         rd_ptr      <= '0;
         cnt         <= '0;
         out_valid_q <= 1'b0;
         o0_q        <= '0;
         o1_q        <= '0;
      end else begin
         if (push) begin
            wr_ptr <= ptr_inc(wr_ptr);
         end
         rd_ptr      <= rd_ptr_nx;
         cnt         <= cnt_nx;
         out_valid_q <= (cnt_nx != '0);
         if (cnt_nx == '0) begin
            o0_q <= '0;
            o1_q <= '0;
         end else begin
            o0_q <= m0;
            o1_q <= m1;
         end
      end
   end

   assign bus.out_valid = out_valid_q;
   assign bus.o0        = o0_q;
   assign bus.o1        = o1_q;
   assign bus.count     = cnt;

`ifdef RANGE_XFER_FIFO_PARITY_EN
   logic o_par_q, par_err_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         o_par_q   <= 1'b0;
         par_err_q <= 1'b0;
      end else begin
         o_par_q <= (cnt_nx == '0) ? 1'b0 : ((^m0) ^ (^m1));
         if (push && (bus.i_par != ((^bus.i0) ^ (^bus.i1)))) begin
            par_err_q <= 1'b1;
         end
      end
   end

   assign bus.o_par   = o_par_q;
   assign bus.par_err = par_err_q;
`endif

endmodule

// File: tb/tb_range_xfer_fifo.sv
// tb/tb_range_xfer_fifo.sv - self-checking bench for range_xfer_fifo (straight DEPTH=3 and cross DEPTH=4 instances)
module tb_range_xfer_fifo;

   localparam int HI = 2;
   localparam int LO = -2;
   localparam int DS = 3;
   localparam int DC = 4;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   range_xfer_fifo_if #(.HI(HI), .LO(LO), .DEPTH(DS)) bs ();
   range_xfer_fifo_if #(.HI(HI), .LO(LO), .DEPTH(DC)) bc ();

   range_xfer_fifo #(.HI(HI), .LO(LO), .DEPTH(DS), .MODE(0)) u_s (
      .clk (clk),
      .rst (rst),
      .bus (bs.slave)
   );

   range_xfer_fifo #(.HI(HI), .LO(LO), .DEPTH(DC), .MODE(1)) u_c (
      .clk (clk),
      .rst (rst),
      .bus (bc.slave)
   );

   int n_chk  = 0;
   int n_fail = 0;

   // Model: each entry is {i0 flat, i1 flat}, flat = left-to-right bit order of the declared range.
   logic [9:0] qs[$];
   logic [9:0] qc[$];

   typedef struct {
      logic       v;
      logic [4:0] a;
      logic [4:0] b;
      logic       rdy;
      logic [1:0] cnt;
      logic       vld;
      logic       irdy;
      logic [4:0] o0;
      logic [4:0] o1;
   } vec_t;

   vec_t tbl[8];

   function automatic logic [4:0] rev(input logic [4:0] x);
      logic [4:0] r;
      for (int j = 0; j < 5; j++) r[j] = x[4 - j];
      return r;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic check_all();
      logic [4:0] f0, f1, e0, e1;
      f0 = bs.o0; f1 = bs.o1;
      e0 = (qs.size() != 0) ? qs[0][9:5] : 5'h00;
      e1 = (qs.size() != 0) ? qs[0][4:0] : 5'h00;
      chk("s_out_valid", 32'(bs.out_valid), 32'(qs.size() != 0));
      chk("s_in_ready",  32'(bs.in_ready),  32'(qs.size() != DS));
      chk("s_count",     32'(bs.count),     32'(qs.size()));
      chk("s_o0",        32'(f0),           32'(e0));
      chk("s_o1",        32'(f1),           32'(e1));
      f0 = bc.o0; f1 = bc.o1;
      e0 = (qc.size() != 0) ? rev(qc[0][4:0]) : 5'h00;
      e1 = (qc.size() != 0) ? rev(qc[0][9:5]) : 5'h00;
      chk("c_out_valid", 32'(bc.out_valid), 32'(qc.size() != 0));
      chk("c_in_ready",  32'(bc.in_ready),  32'(qc.size() != DC));
      chk("c_count",     32'(bc.count),     32'(qc.size()));
      chk("c_o0",        32'(f0),           32'(e0));
      chk("c_o1",        32'(f1),           32'(e1));
   endtask

   task automatic step(input logic r, input logic v, input logic [4:0] a,
                       input logic [4:0] b, input logic rdy);
      logic ps, pps, pc, ppc;
      @(negedge clk);
      rst = r;
      bs.in_valid = v; bs.i0 = a; bs.i1 = b; bs.out_ready = rdy;
      bc.in_valid = v; bc.i0 = a; bc.i1 = b; bc.out_ready = rdy;
      ps  = v   && (qs.size() != DS);
      pps = rdy && (qs.size() != 0);
      pc  = v   && (qc.size() != DC);
      ppc = rdy && (qc.size() != 0);
      @(posedge clk);
      #1;
      if (r) begin
         qs.delete();
         qc.delete();
      end else begin
         if (pps) void'(qs.pop_front());
         if (ps)  qs.push_back({a, b});
         if (ppc) void'(qc.pop_front());
         if (pc)  qc.push_back({a, b});
      end
      check_all();
   endtask

   initial begin
      logic [4:0] t;
      bs.in_valid = 1'b0; bs.i0 = '0; bs.i1 = '0; bs.out_ready = 1'b0;
      bc.in_valid = 1'b0; bc.i0 = '0; bc.i1 = '0; bc.out_ready = 1'b0;

      // Reset held three cycles, with a push offered that must be ignored.
      for (int i = 0; i < 3; i++) begin
         step(1'b1, 1'b1, 5'h1f, 5'h1f, 1'b0);
         chk("rst_out_valid", 32'(bs.out_valid), 32'd0);
         chk("rst_in_ready",  32'(bs.in_ready),  32'd1);
         chk("rst_count",     32'(bs.count),     32'd0);
         t = bs.o0;
         chk("rst_o0", 32'(t), 32'h00);
         t = bs.o1;
         chk("rst_o1", 32'(t), 32'h00);
      end

      // Directed table on the straight DEPTH=3 instance: fill, overflow, full push+pop, wrap, drain.
      tbl[0] = '{1'b1, 5'h13, 5'b01101, 1'b0, 2'd1, 1'b1, 1'b1, 5'h13, 5'b01101};
      tbl[1] = '{1'b1, 5'h0a, 5'h11,    1'b0, 2'd2, 1'b1, 1'b1, 5'h13, 5'b01101};
      tbl[2] = '{1'b1, 5'h1f, 5'h02,    1'b0, 2'd3, 1'b1, 1'b0, 5'h13, 5'b01101};
      tbl[3] = '{1'b1, 5'h07, 5'h07,    1'b0, 2'd3, 1'b1, 1'b0, 5'h13, 5'b01101};
      tbl[4] = '{1'b1, 5'h07, 5'h07,    1'b1, 2'd2, 1'b1, 1'b1, 5'h0a, 5'h11};
      tbl[5] = '{1'b1, 5'h07, 5'h08,    1'b1, 2'd2, 1'b1, 1'b1, 5'h1f, 5'h02};
      tbl[6] = '{1'b0, 5'h00, 5'h00,    1'b1, 2'd1, 1'b1, 1'b1, 5'h07, 5'h08};
      tbl[7] = '{1'b0, 5'h00, 5'h00,    1'b1, 2'd0, 1'b0, 1'b1, 5'h00, 5'h00};
      for (int i = 0; i < 8; i++) begin
         step(1'b0, tbl[i].v, tbl[i].a, tbl[i].b, tbl[i].rdy);
         chk("tbl_count",     32'(bs.count),     32'(tbl[i].cnt));
         chk("tbl_out_valid", 32'(bs.out_valid), 32'(tbl[i].vld));
         chk("tbl_in_ready",  32'(bs.in_ready),  32'(tbl[i].irdy));
         t = bs.o0;
         chk("tbl_o0", 32'(t), 32'(tbl[i].o0));
         t = bs.o1;
         chk("tbl_o1", 32'(t), 32'(tbl[i].o1));
         if (i == 0) begin
            chk("tbl_o1_lo_bit", 32'(bs.o1[-2]), 32'd0);
            chk("tbl_o1_hi_bit", 32'(bs.o1[2]),  32'd1);
         end
      end

      // Cross mode: i0 MSB lands on o1[HI], the LSB position of the ascending bus.
      step(1'b1, 1'b0, 5'h00, 5'h00, 1'b0);
      step(1'b0, 1'b1, 5'b10000, 5'h00, 1'b0);
      chk("cross_o1_hi", 32'(bc.o1[2]),  32'd1);
      chk("cross_o1_lo", 32'(bc.o1[-2]), 32'd0);
      t = bc.o1;
      chk("cross_o1_flat", 32'(t), 32'b00001);

      // Reset with entries held discards them; offered push ignored.
      step(1'b0, 1'b1, 5'h05, 5'h0c, 1'b0);
      chk("pre_rst_count", 32'(bs.count), 32'd2);
      step(1'b1, 1'b1, 5'h09, 5'h09, 1'b0);
      chk("mid_rst_count", 32'(bs.count),     32'd0);
      chk("mid_rst_valid", 32'(bs.out_valid), 32'd0);

      // Randomized traffic against the queue model, with occasional resets.
      for (int i = 0; i < 600; i++) begin
         step(($urandom_range(0, 59) == 0), ($urandom_range(0, 3) != 0),
              5'($urandom), 5'($urandom), ($urandom_range(0, 2) != 0));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
